// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, select codes,
// state and instruction-class enums, and the control-word payload.
package mips_ctrl_pkg;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned SRC_B_W   = 3;
  localparam int unsigned PC_SRC_W  = 2;
  localparam int unsigned REG_DST_W = 2;
  localparam int unsigned WB_SRC_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2a;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd3;

  localparam logic [SRC_B_W-1:0] SRCB_REGB = 3'd0;
  localparam logic [SRC_B_W-1:0] SRCB_FOUR = 3'd1;
  localparam logic [SRC_B_W-1:0] SRCB_SIMM = 3'd2;
  localparam logic [SRC_B_W-1:0] SRCB_ZIMM = 3'd3;
  localparam logic [SRC_B_W-1:0] SRCB_BOFF = 3'd4;

  localparam logic [PC_SRC_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [PC_SRC_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [PC_SRC_W-1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [PC_SRC_W-1:0] PCSRC_REGA   = 2'd3;

  localparam logic [REG_DST_W-1:0] REGDST_RT  = 2'd0;
  localparam logic [REG_DST_W-1:0] REGDST_RD  = 2'd1;
  localparam logic [REG_DST_W-1:0] REGDST_R31 = 2'd2;

  localparam logic [WB_SRC_W-1:0] WB_ALUOUT = 2'd0;
  localparam logic [WB_SRC_W-1:0] WB_MDR    = 2'd1;
  localparam logic [WB_SRC_W-1:0] WB_PC     = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE_ADD, C_RTYPE_SUB, C_RTYPE_SLT, C_JR, C_ADDI, C_XORI,
    C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic                 mem_req;
    logic                 mem_we;
    logic                 iord;
    logic                 ir_we;
    logic                 pc_we;
    logic                 reg_we;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alu_src_a;
    logic [SRC_B_W-1:0]   alu_src_b;
    logic [PC_SRC_W-1:0]  pc_src;
    logic [REG_DST_W-1:0] reg_dst;
    logic [WB_SRC_W-1:0]  wb_src;
    logic                 instr_done;
    logic                 halted;
  } ctrl_t;

  function automatic logic is_rtype_alu(input op_class_t c);
    return (c == C_RTYPE_ADD) || (c == C_RTYPE_SUB) || (c == C_RTYPE_SLT);
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode/funct classifier; anything outside the supported set is ILLEGAL.
module op_class_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output op_class_t          op_class
);

  always_comb begin
    op_class = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  op_class = C_RTYPE_ADD;
          FN_SUB:  op_class = C_RTYPE_SUB;
          FN_SLT:  op_class = C_RTYPE_SLT;
          FN_JR:   op_class = C_JR;
          default: op_class = C_ILLEGAL;
        endcase
      end
      OP_J:    op_class = C_J;
      OP_JAL:  op_class = C_JAL;
      OP_BEQ:  op_class = C_BEQ;
      OP_BNE:  op_class = C_BNE;
      OP_ADDI: op_class = C_ADDI;
      OP_XORI: op_class = C_XORI;
      OP_LW:   op_class = C_LW;
      OP_SW:   op_class = C_SW;
      default: op_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: steps FETCH/DECODE/EXEC/MEM/WB and decodes every
// datapath select and write enable from the state, the registered class and the handshake inputs.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 alu_src_a,
  output logic [SRC_B_W-1:0]   alu_src_b,
  output logic [PC_SRC_W-1:0]  pc_src,
  output logic [REG_DST_W-1:0] reg_dst,
  output logic [WB_SRC_W-1:0]  wb_src,
  output logic                 instr_done,
  output logic                 halted
);

  state_t    state, state_nxt;
  op_class_t cls_q, cls_dec;
  ctrl_t     ctrl;
  logic      retire;

  op_class_decode u_decode (
    .op       (op),
    .funct    (funct),
    .op_class (cls_dec)
  );

  // State and class registers; the class is captured only while decoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cls_q <= C_ILLEGAL;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls_q <= cls_dec;
    end
  end

  // Next state and control word; the handshake and zero flag gate the enables within the cycle.
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    retire    = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BOFF;
        state_nxt      = (cls_dec == C_ILLEGAL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_RTYPE_ADD, C_RTYPE_SUB, C_RTYPE_SLT: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REGB;
            ctrl.alu_op    = (cls_q == C_RTYPE_SUB) ? ALU_SUB :
                             (cls_q == C_RTYPE_SLT) ? ALU_SLT : ALU_ADD;
            state_nxt      = S_WB;
          end
          C_ADDI, C_LW, C_SW: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SIMM;
            state_nxt      = (cls_q == C_ADDI) ? S_WB : S_MEM;
          end
          C_XORI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_ZIMM;
            ctrl.alu_op    = ALU_XOR;
            state_nxt      = S_WB;
          end
          C_BEQ, C_BNE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REGB;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.pc_we     = (cls_q == C_BEQ) ? zero : !zero;
            retire         = 1'b1;
          end
          C_J, C_JAL: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PCSRC_JUMP;
            if (cls_q == C_JAL) begin
              ctrl.reg_we  = 1'b1;
              ctrl.reg_dst = REGDST_R31;
              ctrl.wb_src  = WB_PC;
            end
            retire = 1'b1;
          end
          C_JR: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PCSRC_REGA;
            retire      = 1'b1;
          end
          default: state_nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.mem_we  = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_SW) retire = 1'b1;
          else               state_nxt = S_WB;
        end
      end
      S_WB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = is_rtype_alu(cls_q) ? REGDST_RD : REGDST_RT;
        ctrl.wb_src  = (cls_q == C_LW) ? WB_MDR : WB_ALUOUT;
        retire       = 1'b1;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
    if (retire) begin
      ctrl.instr_done = 1'b1;
      state_nxt       = run ? S_FETCH : S_IDLE;
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign reg_we     = ctrl.reg_we;
  assign alu_op     = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign reg_dst    = ctrl.reg_dst;
  assign wb_src     = ctrl.wb_src;
  assign instr_done = ctrl.instr_done;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a per-instruction cycle trace model
// predicts the control word every cycle; don't-care inputs are randomized.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n, run, zero, mem_ready;
  logic [5:0] op, funct;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we;
  logic [2:0] alu_op, alu_src_b;
  logic       alu_src_a, instr_done, halted;
  logic [1:0] pc_src, reg_dst, wb_src;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .reg_dst(reg_dst), .wb_src(wb_src), .instr_done(instr_done), .halted(halted)
  );

  typedef struct packed {
    logic       run;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
  } stim_t;

  stim_t       stim_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] got_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          idle_now = 1'b1;

  function automatic logic [20:0] obs();
    return {mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_op, alu_src_a,
            alu_src_b, pc_src, reg_dst, wb_src, instr_done, halted};
  endfunction

  // Expected control word, fields in the same order as obs().
  function automatic logic [20:0] w(input bit mreq, mwe, io, irwe, pcwe, rwe,
                                    input int aop, input bit sa, input int sb, ps, rd, ws,
                                    input bit dn, hl);
    return {mreq, mwe, io, irwe, pcwe, rwe, 3'(aop), sa, 3'(sb), 2'(ps), 2'(rd), 2'(ws), dn, hl};
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.run = 1'($urandom); s.op = 6'($urandom); s.funct = 6'($urandom);
    s.zero = 1'($urandom); s.mem_ready = 1'($urandom);
    return s;
  endfunction

  task automatic push(input stim_t s, input logic [20:0] e, input string t);
    stim_q.push_back(s); exp_q.push_back(e); tag_q.push_back(t);
  endtask

  // Reference trace of one instruction: fs/ms = wait cycles on the fetch/data request.
  task automatic add_instr(input logic [5:0] iop, ifn, input logic z, input int fs, ms,
                           input logic run_next);
    stim_t s;
    logic [20:0] ex_w = '0;
    bit rt = 0, wbk = 0, mem = 0, ill = 0, st = 0;
    int wb_rd = 0, wb_ws = 0;
    if (idle_now) begin
      repeat ($urandom_range(0, 2)) begin s = rnd(); s.run = 1'b0; push(s, '0, "idle"); end
      s = rnd(); s.run = 1'b1; push(s, '0, "idle_go");
    end
    for (int i = 0; i <= fs; i++) begin
      s = rnd(); s.mem_ready = (i == fs);
      push(s, w(1, 0, 0, i == fs, i == fs, 0, 0, 0, 1, 0, 0, 0, 0, 0), "fetch");
    end
    s = rnd(); s.op = iop; s.funct = ifn;
    push(s, w(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0), "decode");
    case (iop)
      6'h00: case (ifn)
        6'h20: begin ex_w = w(0,0,0,0,0,0,0,1,0,0,0,0,0,0); wbk = 1; wb_rd = 1; end
        6'h22: begin ex_w = w(0,0,0,0,0,0,1,1,0,0,0,0,0,0); wbk = 1; wb_rd = 1; end
        6'h2a: begin ex_w = w(0,0,0,0,0,0,3,1,0,0,0,0,0,0); wbk = 1; wb_rd = 1; end
        6'h08: begin ex_w = w(0,0,0,0,1,0,0,0,0,3,0,0,1,0); rt = 1; end
        default: ill = 1;
      endcase
      6'h08: begin ex_w = w(0,0,0,0,0,0,0,1,2,0,0,0,0,0); wbk = 1; end
      6'h0e: begin ex_w = w(0,0,0,0,0,0,2,1,3,0,0,0,0,0); wbk = 1; end
      6'h23: begin ex_w = w(0,0,0,0,0,0,0,1,2,0,0,0,0,0); mem = 1; wbk = 1; wb_ws = 1; end
      6'h2b: begin ex_w = w(0,0,0,0,0,0,0,1,2,0,0,0,0,0); mem = 1; st = 1; end
      6'h04: begin ex_w = w(0,0,0,0,z,0,1,1,0,1,0,0,1,0); rt = 1; end
      6'h05: begin ex_w = w(0,0,0,0,!z,0,1,1,0,1,0,0,1,0); rt = 1; end
      6'h02: begin ex_w = w(0,0,0,0,1,0,0,0,0,2,0,0,1,0); rt = 1; end
      6'h03: begin ex_w = w(0,0,0,0,1,1,0,0,0,2,2,2,1,0); rt = 1; end
      default: ill = 1;
    endcase
    if (ill) begin
      repeat (4) push(rnd(), w(0,0,0,0,0,0,0,0,0,0,0,0,0,1), "halt");
      idle_now = 1'b0;
      return;
    end
    s = rnd(); s.zero = z; if (rt) s.run = run_next;
    push(s, ex_w, "exec");
    if (mem) begin
      for (int i = 0; i <= ms; i++) begin
        s = rnd(); s.mem_ready = (i == ms);
        if (i == ms && st) s.run = run_next;
        push(s, w(1, st, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == ms) && st, 0), "mem");
      end
    end
    if (wbk) begin
      s = rnd(); s.run = run_next;
      push(s, w(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, wb_rd, wb_ws, 1, 0), "wb");
    end
    idle_now = !run_next;
  endtask

  // Applies queued inputs at the falling edge and records outputs 1 time unit later.
  task automatic drive_queue();
    stim_t s;
    got_q.delete();
    foreach (stim_q[i]) begin
      s = stim_q[i];
      @(negedge clk);
      run = s.run; op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.mem_ready;
      #1 got_q.push_back(obs());
    end
    stim_q.delete();
  endtask

  task automatic clear_exp();
    exp_q.delete(); tag_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; run = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if (obs() !== 21'h0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs(), 21'h0); end
    @(negedge clk); #1 rst_n = 1'b1;
    idle_now = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stim_t s; s = rnd(); s.run = 1'b0; push(s, '0, "idle_hold");
    end
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  task automatic test_add();
    add_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b1);
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL add_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  task automatic test_lw_stall();
    add_instr(6'h23, 6'($urandom), 1'($urandom), 2, 1, 1'b1);
    add_instr(6'h2b, 6'($urandom), 1'($urandom), 1, 2, 1'b1);
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lwsw_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  task automatic test_branches();
    for (int b = 0; b < 4; b++)
      add_instr((b < 2) ? 6'h04 : 6'h05, 6'($urandom), 1'(b % 2), 0, 0, 1'b1);
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL branch_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  task automatic test_jal();
    add_instr(6'h03, 6'($urandom), 1'($urandom), 0, 0, 1'b1);
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL jal_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  task automatic test_back_to_back();
    logic [11:0] tbl [12];
    logic [11:0] p;
    logic [5:0]  fn;
    tbl = '{12'h020, 12'h022, 12'h02a, 12'h008, 12'h200, 12'h380,
            12'h8c0, 12'hac0, 12'h100, 12'h140, 12'h080, 12'h0c0};
    for (int n = 0; n < 60; n++) begin
      p  = tbl[$urandom_range(0, 11)];
      fn = (p[11:6] == 6'h00) ? p[5:0] : 6'($urandom);
      add_instr(p[11:6], fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                (n == 59) ? 1'b0 : 1'($urandom_range(0, 3) != 0));
    end
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  task automatic test_halt();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) add_instr(6'h3f, 6'($urandom), 1'b0, 0, 0, 1'b1);
      else        add_instr(6'h00, 6'h21, 1'b0, 1, 0, 1'b1);
      drive_queue();
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL halt%0d_%s[%0d]: got %h expected %h", k, tag_q[i], i, got_q[i], exp_q[i]); end
      end
      clear_exp();
      rst_n = 1'b0; run = 1'b0;
      #1;
      checks++;
      if (obs() !== 21'h0) begin errors++; $display("FAIL halt%0d_reset: got %h expected %h", k, obs(), 21'h0); end
      @(negedge clk); #1 rst_n = 1'b1;
      idle_now = 1'b1;
    end
  endtask

  task automatic test_reset_mid_mem();
    stim_t s;
    add_instr(6'h2b, 6'($urandom), 1'b0, 0, 5, 1'b1);
    repeat (4) begin void'(stim_q.pop_back()); void'(exp_q.pop_back()); void'(tag_q.pop_back()); end
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL swmid_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
    rst_n = 1'b0; run = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b00 || obs() !== 21'h0) begin
      errors++; $display("FAIL swmid_async_reset: got %h expected %h", obs(), 21'h0);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    idle_now = 1'b1;
    for (int i = 0; i < 4; i++) begin s = rnd(); s.run = 1'b0; push(s, '0, "idle_after"); end
    add_instr(6'h00, 6'h22, 1'b0, 0, 0, 1'b0);
    drive_queue();
    foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL swmid_%s[%0d]: got %h expected %h", tag_q[i], i, got_q[i], exp_q[i]); end
    end
    clear_exp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branches();
    test_jal();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
